dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Two-port arbiter and sequencer in front of the single-port data memory (load/store unit).
//  Port 0 is the core LSU; port 1 is the debug/DMA master.
//  Grants one request at a time (round-robin) and drives the memory's active-low chip select, load/store and op controls.
//  Captures read data and returns a response.
//  Rejects misaligned accesses with an error and never touches memory for them.
// PARAMETERS
//  AW           32  address width
//  DW           32  data width (fixed 32; byte lanes = 4)
//  CHK_ALIGN    1   1: misaligned half/word -> rsp_err, no access; 0: pass through
// PORTS
//  clk             in   1   single clock; all state on posedge
//  rst             in   1   synchronous, active-high reset
//  req_valid[1:0]  in   2   request valid, per port
//  req_ready[1:0]  out  2   request accepted this cycle when valid&ready
//  req_we[1:0]     in   2   1=store, 0=load
//  req_op[p]       in   3   load: 000 lb,001 lbu,010 lh,011 lhu,100 lw; store: 000 sb,001 sh,010 sw
//  req_addr[p]     in   AW  byte address
//  req_wdata[p]    in   DW  store data
//  rsp_valid[1:0]  out  2   response valid, per port
//  rsp_ready[1:0]  in   2   response consumed when valid&ready
//  rsp_rdata[p]    out  DW  load data (0 for stores/errors)
//  rsp_err[1:0]    out  2   misaligned or illegal op
//  mem_cs          out  1   memory chip select, active-low
//  mem_load_store  out  1   1=load, 0=store
//  mem_load_ops    out  3   to memory
//  mem_store_ops   out  3   to memory
//  mem_addr        out  AW  to memory
//  mem_wdata       out  DW  to memory
//  mem_rdata       in   DW  combinational read data from memory
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0 (port 0 favoured), mem_cs=1, mem_load_store=1, ops=0, mem_addr/wdata=0.
//   Also at reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE. An error request goes IDLE -> RESP directly.
//  IDLE: grant = the valid port; if both valid, grant = rr_ptr.
//   req_ready[grant]=1 combinationally, other port 0. In any other state req_ready=0.
//   On handshake: latch we/op/addr/wdata/port into registers; rr_ptr <= ~grant.
//   Legal request -> ACCESS. Misaligned or illegal op -> RESP with err=1.
//  Misaligned: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0.
//  Illegal op: load op 101-111; store op 011-111.
//  ACCESS (exactly 1 cycle): mem_cs=0, mem_load_store=~we, mem_*_ops/addr/wdata from latched regs.
//   Store: the memory writes on the negedge inside this cycle.
//   Load: mem_rdata is sampled into rsp_rdata at the closing posedge. Then -> RESP.
//  RESP: rsp_valid[port]=1 and holds rdata/err stable until rsp_ready[port]; then -> IDLE, mem outputs return to idle values.
//  Latency: accept->rsp_valid = 2 cycles (legal), 1 cycle (error).
//   Min occupancy 3 cycles per access; no pipelining/outstanding >1.
//  Memory outputs registered (glitch-free cs); outside ACCESS, mem_cs=1.
//  Simultaneous: new request while RESP stalled -> not accepted (ready=0) until back in IDLE.
//   Round-robin alternates under continuous contention; no starvation (bound: 1 access).
//  Reset mid-op: rst in ACCESS does not block that cycle's negedge store (already committed).
//   The response is dropped; all outputs take reset values next cycle.
//  rsp_rdata for stores and errors = 0.
// STRUCTURE
//  dmem_pkg: state_e {IDLE,ACCESS,RESP}; load/store op encodings (LB..LW, SB..SW); is_misaligned() and is_legal_op() functions.
//  Sub-module rr_arb2: 2-way round-robin (req[1:0], ptr, update -> grant onehot).
//  Latch/FSM/response regs live in top.
// TESTING
//  1 Reset: rst 2 cycles -> mem_cs=1, rsp_valid=0, req_ready=0, rr_ptr=0.
//  2 Port0 sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> rsp_rdata=0xDEADBEEF, err=0.
//   Also check rsp_valid exactly 2 cycles after accept.
//  3 Both ports valid continuously, 4 loads each -> grants alternate 0,1,0,1,...
//   Check mem_cs low one cycle per access.
//  4 Port1 lh addr 0x21 -> rsp_err=1 one cycle after accept, mem_cs never low.
//   Also store op 011 -> rsp_err=1.
//  5 Port0 lb 0x13 after sw 0x10 0x80FF0011 -> 0xFFFFFF80; lbu -> 0x00000080.
//  6 rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0.
//   Then rst during ACCESS of sb -> byte written, no response, IDLE.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types, op encodings and request-legality helpers for the data-memory access controller.
package dmem_access_ctrl_pkg;

    localparam int unsigned AW_DEF = 32;
    localparam int unsigned DW_DEF = 32;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic [OP_W-1:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4
    } load_op_e;

    typedef enum logic [OP_W-1:0] {
        SB = 3'd0,
        SH = 3'd1,
        SW = 3'd2
    } store_op_e;

    // Request attributes still needed once the memory registers hold addr/data/op
    typedef struct packed {
        logic we;
        logic port;
    } req_ctl_t;

    function automatic logic is_legal_op(input logic we, input logic [OP_W-1:0] op);
        return we ? (op <= OP_W'(SW)) : (op <= OP_W'(LW));
    endfunction

    function automatic logic is_misaligned(input logic we, input logic [OP_W-1:0] op,
                                           input logic [1:0] addr_lo);
        logic half;
        logic word;
        if (we) begin
            half = (op == OP_W'(SH));
            word = (op == OP_W'(SW));
        end else begin
            half = (op == OP_W'(LH)) || (op == OP_W'(LHU));
            word = (op == OP_W'(LW));
        end
        return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
    endfunction

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Two-port request/response bus between requesters (LSU, debug/DMA) and the access controller.
interface dmem_access_ctrl_if
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);
    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [1:0]                 req_we;
    logic [1:0][OP_W-1:0]       req_op;
    logic [1:0][AW-1:0]         req_addr;
    logic [1:0][DW-1:0]         req_wdata;
    logic [1:0]                 rsp_valid;
    logic [1:0]                 rsp_ready;
    logic [1:0][DW-1:0]         rsp_rdata;
    logic [1:0]                 rsp_err;

    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_access_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port favoured when both request.
module dmem_access_ctrl_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_c_o
);
    logic ptr_q;
    logic ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // The just-served port loses priority on the next contention
    always_comb begin
        gnt_c_o = req_i;
        if (req_i == 2'b11) begin
            gnt_c_o = ptr_q ? 2'b10 : 2'b01;
        end
        ptr_d = ptr_q;
        if (update_i && (gnt_c_o != 2'b00)) begin
            ptr_d = ~gnt_c_o[1];
        end
    end
endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbitrates two requesters onto a single-port data memory: one access at a time, registered
// memory controls, captured load data and per-port responses; bad requests never reach memory.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter bit          CHK_ALIGN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_access_ctrl_if.slave    bus,
    output logic                 mem_cs,
    output logic                 mem_load_store,
    output logic [OP_W-1:0]      mem_load_ops,
    output logic [OP_W-1:0]      mem_store_ops,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);
    state_e          state_q, state_d;
    req_ctl_t        ctl_q, ctl_d;
    logic [1:0]      rsp_valid_q, rsp_valid_d;
    logic [1:0]      err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            mem_cs_q, mem_cs_d;
    logic            mem_ls_q, mem_ls_d;
    logic [OP_W-1:0] mem_lops_q, mem_lops_d;
    logic [OP_W-1:0] mem_sops_q, mem_sops_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

    logic [1:0]      gnt_c;
    logic [1:0]      req_ready_c;
    logic            arb_update_c;
    logic            sel_c;
    logic            sel_we_c;
    logic [OP_W-1:0] sel_op_c;
    logic            sel_err_c;

    dmem_access_ctrl_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (bus.req_valid),
        .update_i (arb_update_c),
        .gnt_c_o  (gnt_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ctl_q       <= '0;
            rsp_valid_q <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            mem_cs_q    <= 1'b1;
            mem_ls_q    <= 1'b1;
            mem_lops_q  <= '0;
            mem_sops_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ctl_q       <= ctl_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_cs_q    <= mem_cs_d;
            mem_ls_q    <= mem_ls_d;
            mem_lops_q  <= mem_lops_d;
            mem_sops_q  <= mem_sops_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign sel_c     = gnt_c[1];
    assign sel_we_c  = bus.req_we[sel_c];
    assign sel_op_c  = bus.req_op[sel_c];
    assign sel_err_c = !is_legal_op(sel_we_c, sel_op_c) ||
                       (CHK_ALIGN && is_misaligned(sel_we_c, sel_op_c, bus.req_addr[sel_c][1:0]));

    // Memory controls default to idle so chip select is only low during ACCESS
    always_comb begin
        state_d      = state_q;
        ctl_d        = ctl_q;
        rsp_valid_d  = rsp_valid_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        mem_cs_d     = 1'b1;
        mem_ls_d     = 1'b1;
        mem_lops_d   = '0;
        mem_sops_d   = '0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        req_ready_c  = 2'b00;
        arb_update_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready_c = gnt_c;
                if ((bus.req_valid & gnt_c) != 2'b00) begin
                    arb_update_c = 1'b1;
                    ctl_d        = '{we: sel_we_c, port: sel_c};
                    rdata_d      = '0;
                    if (sel_err_c) begin
                        state_d     = RESP;
                        rsp_valid_d = port_onehot(sel_c);
                        err_d       = port_onehot(sel_c);
                    end else begin
                        state_d     = ACCESS;
                        mem_cs_d    = 1'b0;
                        mem_ls_d    = ~sel_we_c;
                        mem_lops_d  = sel_we_c ? '0 : sel_op_c;
                        mem_sops_d  = sel_we_c ? sel_op_c : '0;
                        mem_addr_d  = bus.req_addr[sel_c];
                        mem_wdata_d = sel_we_c ? bus.req_wdata[sel_c] : '0;
                    end
                end
            end
            ACCESS: begin
                state_d     = RESP;
                rsp_valid_d = port_onehot(ctl_q.port);
                rdata_d     = ctl_q.we ? '0 : mem_rdata;
            end
            RESP: begin
                if ((rsp_valid_q & bus.rsp_ready) != 2'b00) begin
                    state_d     = IDLE;
                    rsp_valid_d = '0;
                    err_d       = '0;
                    rdata_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = {rdata_q, rdata_q};

    assign mem_cs         = mem_cs_q;
    assign mem_load_store = mem_ls_q;
    assign mem_load_ops   = mem_lops_q;
    assign mem_store_ops  = mem_sops_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a byte-addressed memory model handling the op encodings.
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_cs;
    logic        mem_load_store;
    logic [2:0]  mem_load_ops;
    logic [2:0]  mem_store_ops;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl_if #(.AW(32), .DW(32)) bus ();

    dmem_access_ctrl #(.AW(32), .DW(32), .CHK_ALIGN(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .mem_cs         (mem_cs),
        .mem_load_store (mem_load_store),
        .mem_load_ops   (mem_load_ops),
        .mem_store_ops  (mem_store_ops),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    // Memory model: little-endian bytes, combinational read, store on negedge while selected
    logic [7:0] mem [0:255] = '{default: 8'h00};
    logic [7:0] a0, a1, a2, a3;
    assign a0 = mem_addr[7:0];
    assign a1 = a0 + 8'd1;
    assign a2 = a0 + 8'd2;
    assign a3 = a0 + 8'd3;

    always_comb begin
        mem_rdata = 32'h0;
        if (!mem_cs && mem_load_store) begin
            case (mem_load_ops)
                3'd0: mem_rdata = {{24{mem[a0][7]}}, mem[a0]};
                3'd1: mem_rdata = {24'h0, mem[a0]};
                3'd2: mem_rdata = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
                3'd3: mem_rdata = {16'h0, mem[a1], mem[a0]};
                3'd4: mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
                default: mem_rdata = 32'h0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!mem_cs && !mem_load_store) begin
            case (mem_store_ops)
                3'd0: mem[a0] <= mem_wdata[7:0];
                3'd1: begin
                    mem[a0] <= mem_wdata[7:0];
                    mem[a1] <= mem_wdata[15:8];
                end
                3'd2: begin
                    mem[a0] <= mem_wdata[7:0];
                    mem[a1] <= mem_wdata[15:8];
                    mem[a2] <= mem_wdata[23:16];
                    mem[a3] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // One request on port p with an always-ready consumer; reports data, error, latency and cs-low cycles
    task automatic do_req(input logic p, input logic we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int cs_lo);
        int g;
        bus.req_we[p]    = we;
        bus.req_op[p]    = op;
        bus.req_addr[p]  = addr;
        bus.req_wdata[p] = wdata;
        bus.req_valid[p] = 1'b1;
        bus.rsp_ready[p] = 1'b1;
        g = 0;
        @(negedge clk);
        while (!bus.req_ready[p] && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("accept_in_time", 32'(g < 20), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
        lat   = 0;
        cs_lo = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!mem_cs) cs_lo++;
        end while (!bus.rsp_valid[p] && lat < 10);
        rdata = bus.rsp_rdata[p];
        err   = bus.rsp_err[p];
        @(posedge clk); #1;
        bus.rsp_ready[p] = 1'b0;
    endtask

    typedef struct {
        logic        p;
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, cs_lo;
        int          k, cs_total, rsp_ok;
        int          cnt[2];
        int          order[8];
        logic        first;

        //            p     we    op    addr         wdata          err   rdata
        vecs[0]  = '{1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b0, 1'b0, 3'd4, 32'h10, 32'h00000000, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b1, 3'd2, 32'h10, 32'h80FF0011, 1'b0, 32'h00000000};
        vecs[3]  = '{1'b0, 1'b0, 3'd0, 32'h13, 32'h00000000, 1'b0, 32'hFFFFFF80};
        vecs[4]  = '{1'b0, 1'b0, 3'd1, 32'h13, 32'h00000000, 1'b0, 32'h00000080};
        vecs[5]  = '{1'b1, 1'b0, 3'd2, 32'h12, 32'h00000000, 1'b0, 32'hFFFF80FF};
        vecs[6]  = '{1'b1, 1'b0, 3'd3, 32'h12, 32'h00000000, 1'b0, 32'h000080FF};
        vecs[7]  = '{1'b1, 1'b0, 3'd2, 32'h21, 32'h00000000, 1'b1, 32'h00000000};
        vecs[8]  = '{1'b0, 1'b1, 3'd2, 32'h12, 32'h12345678, 1'b1, 32'h00000000};
        vecs[9]  = '{1'b1, 1'b1, 3'd3, 32'h20, 32'h11111111, 1'b1, 32'h00000000};
        vecs[10] = '{1'b0, 1'b0, 3'd5, 32'h20, 32'h00000000, 1'b1, 32'h00000000};
        vecs[11] = '{1'b1, 1'b1, 3'd1, 32'h22, 32'h0000BEEF, 1'b0, 32'h00000000};
        vecs[12] = '{1'b0, 1'b1, 3'd0, 32'h21, 32'h000000A5, 1'b0, 32'h00000000};
        vecs[13] = '{1'b1, 1'b0, 3'd4, 32'h20, 32'h00000000, 1'b0, 32'hBEEFA500};
        vecs[14] = '{1'b0, 1'b0, 3'd4, 32'h10, 32'h00000000, 1'b0, 32'h80FF0011};

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_cs", 32'(mem_cs), 32'd1);
        chk("rst_load_store", 32'(mem_load_store), 32'd1);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata[0], 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;

        // Single-port vectors: data, error, latency and memory-touch per request
        for (int i = 0; i < 15; i++) begin
            do_req(vecs[i].p, vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wdata,
                   rd, er, lat, cs_lo);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].err));
            chk($sformatf("v%0d_latency", i), 32'(lat), vecs[i].err ? 32'd1 : 32'd2);
            chk($sformatf("v%0d_cs_low", i), 32'(cs_lo), vecs[i].err ? 32'd0 : 32'd1);
        end

        // Continuous contention: 4 loads per port, grants must alternate
        first          = ~vecs[14].p;
        bus.req_we     = 2'b00;
        bus.req_op[0]  = 3'd4;
        bus.req_addr[0] = 32'h10;
        bus.req_op[1]  = 3'd4;
        bus.req_addr[1] = 32'h20;
        bus.rsp_ready  = 2'b11;
        bus.req_valid  = 2'b11;
        k = 0; cs_total = 0; rsp_ok = 0; cnt[0] = 0; cnt[1] = 0;
        for (int i = 0; i < 8; i++) order[i] = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!mem_cs) cs_total++;
            if (bus.rsp_valid[0] && bus.rsp_rdata[0] == 32'h80FF0011) rsp_ok++;
            if (bus.rsp_valid[1] && bus.rsp_rdata[1] == 32'hBEEFA500) rsp_ok++;
            for (int p = 0; p < 2; p++) begin
                if (bus.req_valid[p] && bus.req_ready[p]) begin
                    if (k < 8) order[k] = p;
                    k++;
                    cnt[p]++;
                end
            end
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) if (cnt[p] == 4) bus.req_valid[p] = 1'b0;
        end
        bus.rsp_ready = 2'b00;
        for (int i = 0; i < 8; i++)
            chk($sformatf("rr_grant%0d", i), 32'(order[i]), 32'(first ^ i[0]));
        chk("rr_accepts", 32'(k), 32'd8);
        chk("rr_cs_low_cycles", 32'(cs_total), 32'd8);
        chk("rr_responses", 32'(rsp_ok), 32'd8);

        // Stalled response: held stable, no new request accepted
        bus.req_op[0]    = 3'd4;
        bus.req_addr[0]  = 32'h10;
        bus.req_valid[0] = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.req_ready[0] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("stall_accept", 32'(k < 20), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        bus.req_op[1]    = 3'd4;
        bus.req_addr[1]  = 32'h20;
        bus.req_valid[1] = 1'b1;
        k = 0;
        @(negedge clk);
        chk("stall_ready_in_access", 32'(bus.req_ready), 32'd0);
        while (!bus.rsp_valid[0] && k < 10) begin
            @(negedge clk);
            k++;
        end
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_valid", c), 32'(bus.rsp_valid[0]), 32'd1);
            chk($sformatf("stall%0d_rdata", c), bus.rsp_rdata[0], 32'h80FF0011);
            chk($sformatf("stall%0d_ready", c), 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        bus.rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready[0] = 1'b0;
        @(negedge clk);
        chk("stall_released", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;

        // Reset during the ACCESS cycle of a byte store
        bus.req_we[0]    = 1'b1;
        bus.req_op[0]    = 3'd0;
        bus.req_addr[0]  = 32'h30;
        bus.req_wdata[0] = 32'h0000005A;
        bus.rsp_ready[0] = 1'b1;
        bus.req_valid[0] = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.req_ready[0] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("sb_accept", 32'(k < 20), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("sb_cs_in_access", 32'(mem_cs), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("midrst%0d_rsp_valid", c), 32'(bus.rsp_valid), 32'd0);
            chk($sformatf("midrst%0d_mem_cs", c), 32'(mem_cs), 32'd1);
        end
        chk("midrst_byte_written", 32'(mem[8'h30]), 32'h5A);
        bus.rsp_ready[0] = 1'b0;

        // Pointer back at port 0 after reset
        @(posedge clk); #1;
        bus.req_we    = 2'b00;
        bus.req_op[0] = 3'd4;
        bus.req_op[1] = 3'd4;
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("midrst_rr_ptr", 32'(bus.req_ready), 32'd1);
        #1 bus.req_valid = 2'b00;
        @(posedge clk); #1;

        do_req(1'b0, 1'b0, 3'd4, 32'h30, 32'h0, rd, er, lat, cs_lo);
        chk("midrst_readback", rd, 32'h0000005A);
        chk("midrst_readback_lat", 32'(lat), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
